// File: rtl/mem_read_arbiter.sv
// Two-requester round-robin arbiter for the shared line-wide memory read port
// (requester 0 = instruction cache, requester 1 = data cache).
// Ports: clk_i/rstn_i; per requester read_en_i/addr_i in, read_valid_o/read_data_o out;
//        mem_addr_o/mem_read_en_o to memory, mem_read_valid_i/mem_read_data_i back.
// Latency: grant one cycle after request; response forwarded combinationally.
module mem_read_arbiter #(
  parameter int AddrWidth = 32,
  parameter int LineSize  = 128
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req0_read_en_i,
  input  logic [AddrWidth-1:0] req0_addr_i,
  output logic                 req0_read_valid_o,
  output logic [LineSize-1:0]  req0_read_data_o,
  input  logic                 req1_read_en_i,
  input  logic [AddrWidth-1:0] req1_addr_i,
  output logic                 req1_read_valid_o,
  output logic [LineSize-1:0]  req1_read_data_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_read_en_o,
  input  logic                 mem_read_valid_i,
  input  logic [LineSize-1:0]  mem_read_data_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [AddrWidth-1:0] addr_q, addr_d;

  logic owner_req;
  logic active;
  logic fwd;

  assign owner_req = grant_q ? req1_read_en_i : req0_read_en_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        // Memory valids seen here are stray and deliberately ignored.
        if (req0_read_en_i && req1_read_en_i) begin
          // Tie: the requester not served most recently wins.
          if (last_q) begin
            grant_d = 1'b0;
            addr_d  = req0_addr_i;
          end else begin
            grant_d = 1'b1;
            addr_d  = req1_addr_i;
          end
          state_d = BUSY;
        end else if (req0_read_en_i) begin
          grant_d = 1'b0;
          addr_d  = req0_addr_i;
          state_d = BUSY;
        end else if (req1_read_en_i) begin
          grant_d = 1'b1;
          addr_d  = req1_addr_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_read_valid_i) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (!owner_req) begin
          // Owner gave up; memory read is still in flight and must complete.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_read_valid_i) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // Memory side is driven straight from registered state, so it is glitch-free.
  assign active        = (state_q != IDLE);
  assign mem_read_en_o = active;
  assign mem_addr_o    = active ? addr_q : '0;

  // Only a live (non-drained) transaction forwards the response, to its owner only.
  assign fwd               = (state_q == BUSY) && mem_read_valid_i;
  assign req0_read_valid_o = fwd && !grant_q;
  assign req1_read_valid_o = fwd && grant_q;
  assign req0_read_data_o  = req0_read_valid_o ? mem_read_data_i : '0;
  assign req1_read_data_o  = req1_read_valid_o ? mem_read_data_i : '0;

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-requester arbiter for the single line-wide memory read port shared by the instruction cache and the data cache. Each cache drives the same request protocol as the memory expects: request held with stable address until a one-cycle valid. The arbiter grants one requester at a time with round-robin priority, latches the granted address, forwards the response to the owner only, and drains an in-flight memory read if the owner withdraws. It sits between the two caches and the memory model.

## Interface
Parameters:
- `AddrWidth`, 32: address width.
- `LineSize`, 128: line width in bits (4 words).

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `req0_read_en_i`  in  1  requester 0 (instruction cache) read request.
- `req0_addr_i`  in  AddrWidth  requester 0 line address (offset bits zero).
- `req0_read_valid_o`  out  1  response valid to requester 0.
- `req0_read_data_o`  out  LineSize  response line to requester 0.
- `req1_read_en_i`, `req1_addr_i`, `req1_read_valid_o`, `req1_read_data_o`: same for requester 1 (data cache).
- `mem_addr_o`  out  AddrWidth  address to memory.
- `mem_read_en_o`  out  1  read request to memory.
- `mem_read_valid_i`  in  1  memory response valid, one cycle.
- `mem_read_data_i`  in  LineSize  memory response line.

## Operation
- State register: IDLE, BUSY, DRAIN. Registers: `grant` (1 bit), `last` (1 bit, last requester served), `addr_q` (AddrWidth).
- Reset: state=IDLE, grant=0, last=1, addr_q=0. All outputs 0 during and right after reset.
- IDLE: if exactly one reqN_read_en_i high -> grant=N, addr_q=reqN_addr_i, BUSY. If both high -> grant=!last (requester 0 wins the first tie after reset). If none -> stay.
- BUSY: mem_read_en_o=1, mem_addr_o=addr_q.
  - mem_read_valid_i=1 -> reqgrant_read_valid_o=1, reqgrant_read_data_o=mem_read_data_i in that cycle (combinational); last=grant; next IDLE.
  - mem_read_valid_i=0 and reqgrant_read_en_i=0 (withdrawal) -> DRAIN.
  - Owner changing its address while in BUSY has no effect; addr_q is used.
- DRAIN: mem_read_en_o=1, mem_addr_o=addr_q; no read_valid_o to either requester. On mem_read_valid_i -> last=grant, IDLE; data discarded.
- Outputs outside BUSY: mem_read_en_o=0 and mem_addr_o=0 in IDLE; both reqN_read_valid_o=0 and reqN_read_data_o=0 except the owner in its valid cycle. Non-owner always sees valid=0, data=0.
- mem_read_valid_i in IDLE (stray or pre-reset response) is ignored.
- The non-granted requester keeps its request high; it is not acknowledged and is served after the current transaction.

## Timing
- Grant latency: request high in cycle 0 while in IDLE -> mem_read_en_o high from cycle 1.
- Response: forwarded the same cycle mem_read_valid_i is high. Zero added latency.
- Turnaround: state is IDLE in the cycle after the valid cycle. The next grant is decided then, and mem_read_en_o is high again one cycle later. There is a minimum one-cycle gap with mem_read_en_o=0 between transactions.
- Request during the owner's response cycle is not sampled; the owner's request in that cycle is ignored.
- Round-robin: with both requesting continuously, grants alternate 0,1,0,1.
- Reset asserted mid-BUSY/DRAIN: immediate return to IDLE and outputs 0. A memory valid arriving later is ignored.

## Test plan
- Single request: req0_read_en_i=1, addr 0x0000_1230 in cycle 0; memory valid in cycle 4 with data 0xDDDD_CCCC_BBBB_AAAA_… -> mem_read_en_o=1, mem_addr_o=0x1230 in cycles 1–4; req0_read_valid_o=1 with that data in cycle 4 only; req1_read_valid_o=0 throughout; mem_read_en_o=0 in cycle 5.
- Tie after reset: both request in cycle 0 (0x100, 0x200), memory latency 2 -> 0x100 served first. Then IDLE for one cycle, then 0x200 served to req1.
- Continuous contention over 6 transactions -> grant order 0,1,0,1,0,1; each requester receives only its own data.
- Withdrawal: req1 granted, drops its request in cycle 2, memory valid in cycle 5 -> DRAIN in cycles 3–5 with mem_read_en_o=1 and address unchanged; no req1_read_valid_o; next grant no earlier than cycle 6.
- Address change mid-transaction: req0 changes address to 0x440 in cycle 2 while BUSY -> mem_addr_o stays at the latched 0x400 until the valid cycle.
- Reset during BUSY, then stray mem_read_valid_i in IDLE -> all outputs 0, no read_valid_o pulse; the following request is granted normally with req0 winning the tie.
